// File: rtl/jtbubl_objdraw.sv
// Tile-row object drawer: fetches 32-bit pixel words from ROM and writes
// {pal, pen} pixels into a line buffer, 8 or 16 pixels per request.
module jtbubl_objdraw #(
  parameter int unsigned CW         = 10,
  parameter int unsigned PW         = 4,
  parameter int unsigned XW         = 9,
  parameter int unsigned TILEW      = 8,
  parameter int unsigned VW         = 3,
  parameter int unsigned TRANSP_EN  = 1,
  parameter logic [3:0]  TRANSP_PEN = 4'hF,
  localparam int unsigned RW        = CW + VW + ((TILEW == 16) ? 1 : 0)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          draw,
  input  logic [CW-1:0] code,
  input  logic [XW-1:0] xpos,
  input  logic [VW-1:0] ysub,
  input  logic          hflip,
  input  logic          vflip,
  input  logic [PW-1:0] pal,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic [XW-1:0] buf_addr,
  output logic [PW+3:0] buf_data,
  output logic          buf_we
);

  localparam bit SKIP_EN = (TRANSP_EN != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_WAIT, ST_DRAW} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          half, half_nxt;
  logic [31:0]   word, word_nxt;
  logic [XW-1:0] xbase, xbase_nxt;
  logic [PW-1:0] pal_r, pal_nxt;
  logic          hflip_r, hflip_nxt;
  logic          busy_nxt, done_nxt, rom_cs_nxt, buf_we_nxt;
  logic [RW-1:0] rom_addr_nxt, req_addr;
  logic [XW-1:0] buf_addr_nxt;
  logic [PW+3:0] buf_data_nxt;
  logic [VW-1:0] row;
  logic [31:0]   src;
  logic [2:0]    idx, pix;
  logic [3:0]    pen;
  logic          visible;
  logic          last_half;

  // Pen of unflipped pixel p: four bit-planes spaced 4 bits apart, upper
  // four pixels live in the upper 16 bits of the word.
  function automatic logic [3:0] pen_of(input logic [31:0] w, input logic [2:0] p);
    logic [4:0] base;
    base   = {p[2], 2'b00, p[1:0]};
    pen_of = {w[base], w[base + 5'd4], w[base + 5'd8], w[base + 5'd12]};
  endfunction

  assign row = ysub ^ {VW{vflip}};

  generate
    if (TILEW == 16) begin : g_w16
      assign req_addr = {code, row, hflip};
    end else begin : g_w8
      assign req_addr = {code, row};
    end
  endgenerate

  // Pixel 0 comes straight from the bus on the capture cycle, later ones from the held word.
  assign src       = (state == ST_WAIT) ? rom_data : word;
  assign idx       = (state == ST_WAIT) ? 3'd0 : cnt + 3'd1;
  assign pix       = hflip_r ? ~idx : idx;
  assign pen       = pen_of(src, pix);
  assign visible   = !(SKIP_EN && (pen == TRANSP_PEN));
  assign last_half = (TILEW != 16) || half;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (draw) state_nxt = ST_GUARD;
        ST_GUARD: state_nxt = ST_WAIT;
        ST_WAIT:  if (rom_ok) state_nxt = ST_DRAW;
        ST_DRAW:  if (cnt == 3'd7) state_nxt = last_half ? ST_IDLE : ST_GUARD;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    cnt_nxt      = cnt;
    half_nxt     = half;
    word_nxt     = word;
    xbase_nxt    = xbase;
    pal_nxt      = pal_r;
    hflip_nxt    = hflip_r;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rom_cs_nxt   = rom_cs;
    rom_addr_nxt = rom_addr;
    buf_we_nxt   = 1'b0;
    buf_addr_nxt = buf_addr;
    buf_data_nxt = buf_data;
    if (abort) begin
      busy_nxt   = 1'b0;
      rom_cs_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (draw) begin
            xbase_nxt    = xpos;
            pal_nxt      = pal;
            hflip_nxt    = hflip;
            half_nxt     = 1'b0;
            busy_nxt     = 1'b1;
            rom_cs_nxt   = 1'b1;
            rom_addr_nxt = req_addr;
          end
        end
        ST_WAIT: begin
          if (rom_ok) begin
            word_nxt     = rom_data;
            rom_cs_nxt   = 1'b0;
            cnt_nxt      = 3'd0;
            buf_addr_nxt = xbase + XW'({half, 3'b000});
            buf_data_nxt = {pal_r, pen};
            buf_we_nxt   = visible;
          end
        end
        ST_DRAW: begin
          if (cnt == 3'd7) begin
            if (last_half) begin
              busy_nxt = 1'b0;
              done_nxt = 1'b1;
            end else begin
              // Second word of a 16-pixel row is the other half of the pair.
              half_nxt     = 1'b1;
              rom_cs_nxt   = 1'b1;
              rom_addr_nxt = {rom_addr[RW-1:1], ~rom_addr[0]};
            end
          end else begin
            cnt_nxt      = cnt + 3'd1;
            buf_addr_nxt = buf_addr + XW'(1);
            buf_data_nxt = {pal_r, pen};
            buf_we_nxt   = visible;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      half     <= 1'b0;
      word     <= '0;
      xbase    <= '0;
      pal_r    <= '0;
      hflip_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      cnt      <= cnt_nxt;
      half     <= half_nxt;
      word     <= word_nxt;
      xbase    <= xbase_nxt;
      pal_r    <= pal_nxt;
      hflip_r  <= hflip_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rom_cs   <= rom_cs_nxt;
      rom_addr <= rom_addr_nxt;
      buf_we   <= buf_we_nxt;
      buf_addr <= buf_addr_nxt;
      buf_data <= buf_data_nxt;
    end
  end

endmodule

// File: tb/tb_jtbubl_objdraw.sv
// Scoreboard bench: an 8-wide transparent drawer and a 16-wide opaque drawer
// against a ROM model with stale-ok behaviour and a per-request pixel model.
module tb_jtbubl_objdraw;

  localparam int unsigned CW  = 10;
  localparam int unsigned PW  = 4;
  localparam int unsigned XW  = 9;
  localparam int unsigned RWA = 13;
  localparam int unsigned RWB = 15;

  logic          clk = 1'b0, rst = 1'b1, abort = 1'b0;
  logic          draw_a = 1'b0, draw_b = 1'b0;
  logic [CW-1:0] code = '0;
  logic [XW-1:0] xpos = '0;
  logic [3:0]    ysub = '0;
  logic          hflip = 1'b0, vflip = 1'b0;
  logic [PW-1:0] pal = '0;

  logic           busy_a, done_a, rom_cs_a, buf_we_a;
  logic           rom_ok_a = 1'b0;
  logic [31:0]    rom_data_a = '0;
  logic [RWA-1:0] rom_addr_a;
  logic [XW-1:0]  buf_addr_a;
  logic [PW+3:0]  buf_data_a;

  logic           busy_b, done_b, rom_cs_b, buf_we_b;
  logic           rom_ok_b = 1'b0;
  logic [31:0]    rom_data_b = '0;
  logic [RWB-1:0] rom_addr_b;
  logic [XW-1:0]  buf_addr_b;
  logic [PW+3:0]  buf_data_b;

  jtbubl_objdraw #(.CW(CW), .PW(PW), .XW(XW), .TILEW(8), .VW(3),
                   .TRANSP_EN(1), .TRANSP_PEN(4'hF)) u_a (
    .clk(clk), .rst(rst), .abort(abort), .draw(draw_a), .code(code),
    .xpos(xpos), .ysub(ysub[2:0]), .hflip(hflip), .vflip(vflip), .pal(pal),
    .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a), .rom_cs(rom_cs_a),
    .rom_ok(rom_ok_a), .rom_data(rom_data_a), .buf_addr(buf_addr_a),
    .buf_data(buf_data_a), .buf_we(buf_we_a));

  jtbubl_objdraw #(.CW(CW), .PW(PW), .XW(XW), .TILEW(16), .VW(4),
                   .TRANSP_EN(0), .TRANSP_PEN(4'hF)) u_b (
    .clk(clk), .rst(rst), .abort(abort), .draw(draw_b), .code(code),
    .xpos(xpos), .ysub(ysub), .hflip(hflip), .vflip(vflip), .pal(pal),
    .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b), .rom_cs(rom_cs_b),
    .rom_ok(rom_ok_b), .rom_data(rom_data_b), .buf_addr(buf_addr_b),
    .buf_data(buf_data_b), .buf_we(buf_we_b));

  always #5 clk = ~clk;

  logic [31:0] mem_a [8192];
  logic [31:0] mem_b [32768];

  typedef struct {
    int u;
    int kind;   // 0 pixel write, 1 done, 2 fetch
    int addr;
    int data;
    int off;
  } ev_t;

  ev_t evq[$];
  int  checks = 0, errors = 0, cyc = 0;
  bit  hold_low = 1'b0;
  bit  got;
  bit  mpcs [2];
  int  mt0 [2];
  bit  rpcs_a = 0, rpcs_b = 0, rpend_a = 0, rpend_b = 0;
  int  rpaddr_a = 0, rpaddr_b = 0, rlat_a = 0, rlat_b = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int u, input int kind, input int addr, input int data, input int off);
    ev_t ev;
    ev.u = u; ev.kind = kind; ev.addr = addr; ev.data = data; ev.off = off;
    evq.push_back(ev);
  endtask

  // Reference: screen pixel k shows tile pixel k (or TILEW-1-k when flipped).
  task automatic push_req(input int u, input int c, input int x, input int y,
                          input bit hf, input bit vf, input int p);
    int tw, vw, h, row, base;
    tw   = (u != 0) ? 16 : 8;
    vw   = (u != 0) ? 4 : 3;
    h    = (u != 0) ? 1 : 0;
    row  = vf ? ((1 << vw) - 1 - y) : y;
    base = (c << (vw + h)) + (row << h);
    for (int hk = 0; hk < tw / 8; hk++) begin
      int first_t;
      first_t = hf ? (tw - 1 - hk * 8) : (hk * 8);
      push_ev(u, 2, base + first_t / 8, 0, -1);
      for (int e = 0; e < 8; e++) begin
        int k, t, i, b, pen;
        logic [31:0] w;
        k   = hk * 8 + e;
        t   = hf ? (tw - 1 - k) : k;
        w   = (u != 0) ? mem_b[base + t / 8] : mem_a[base + t / 8];
        i   = t % 8;
        b   = (i < 4) ? 0 : 16;
        i   = i % 4;
        pen = 8 * int'(w[b + i]) + 4 * int'(w[b + 4 + i]) + 2 * int'(w[b + 8 + i]) + int'(w[b + 12 + i]);
        if (!(u == 0 && pen == 15))
          push_ev(u, 0, (x + k) % 512, p * 16 + pen, e);
      end
    end
    push_ev(u, 1, 0, 0, 8);
  endtask

  task automatic pop_cmp(input int u, input int kind, input int addr, input int data,
                         input int off, input string nm);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL %s inst%0d unexpected: addr %0h data %0h off %0d, required no event",
               nm, u, addr, data, off);
      return;
    end
    e = evq.pop_front();
    if (e.u != u || e.kind != kind || e.addr != addr || e.data != data ||
        (e.off >= 0 && e.off != off)) begin
      errors++;
      $display("FAIL %s inst%0d: got kind %0d addr %0h data %0h off %0d, required inst%0d kind %0d addr %0h data %0h off %0d",
               nm, u, kind, addr, data, off, e.u, e.kind, e.addr, e.data, e.off);
    end
  endtask

  // Pixel offsets are measured from the cycle rom_cs drops (the capture).
  task automatic mon(input int u, input logic cs, input int raddr, input logic we,
                     input int baddr, input int bdata, input logic dn, input logic bz);
    if (cs && !mpcs[u]) pop_cmp(u, 2, raddr, 0, 0, "fetch");
    if (!cs && mpcs[u] && bz) mt0[u] = cyc;
    if (we) pop_cmp(u, 0, baddr, bdata, cyc - mt0[u], "pixel");
    if (dn) pop_cmp(u, 1, 0, int'(bz), cyc - mt0[u], "done");
    mpcs[u] = cs;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, rom_cs_a, int'(rom_addr_a), buf_we_a, int'(buf_addr_a), int'(buf_data_a), done_a, busy_a);
    mon(1, rom_cs_b, int'(rom_addr_b), buf_we_b, int'(buf_addr_b), int'(buf_data_b), done_b, busy_b);
  end

  // ROM: on a new address rom_ok stays high one cycle with stale data, then real data after latency.
  task automatic rom_step(input logic cs, input int addr, input logic [31:0] mw,
                          inout bit pcs, inout int paddr, inout bit pend, inout int lat,
                          inout logic ok, inout logic [31:0] data);
    if (rst) begin
      ok = 1'b0; pend = 1'b0; pcs = 1'b0;
      return;
    end
    if (cs && (!pcs || addr != paddr)) begin
      ok = 1'b1; data = $urandom; pend = 1'b1; lat = $urandom_range(0, 3);
    end else if (pend) begin
      if (hold_low || lat > 0) begin
        ok = 1'b0;
        if (lat > 0) lat--;
      end else begin
        ok = 1'b1; data = mw; pend = 1'b0;
      end
    end
    pcs = cs; paddr = addr;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rom_step(rom_cs_a, int'(rom_addr_a), mem_a[rom_addr_a], rpcs_a, rpaddr_a, rpend_a, rlat_a, rom_ok_a, rom_data_a);
      rom_step(rom_cs_b, int'(rom_addr_b), mem_b[rom_addr_b], rpcs_b, rpaddr_b, rpend_b, rlat_b, rom_ok_b, rom_data_b);
    end
  end

  task automatic wait_done(input int u, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      draw_a = 1'b0; draw_b = 1'b0;
      code = CW'($urandom); xpos = XW'($urandom); ysub = 4'($urandom);
      hflip = 1'($urandom); vflip = 1'($urandom); pal = PW'($urandom);
      if ((u != 0) ? done_b : done_a) seen = 1'b1;
      else if (((u != 0) ? busy_b : busy_a) && $urandom_range(0, 5) == 0) begin
        if (u != 0) draw_b = 1'b1; else draw_a = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout inst%0d: got no done, required done within %0d cycles", u, budget);
    end
    #1;
    chk("drained", evq.size(), 0);
    evq.delete();
  endtask

  task automatic issue(input int u, input int c, input int x, input int y,
                       input bit hf, input bit vf, input int p);
    push_req(u, c, x, y, hf, vf, p);
    code = CW'(c); xpos = XW'(x); ysub = 4'(y);
    hflip = hf; vflip = vf; pal = PW'(p);
    if (u != 0) draw_b = 1'b1; else draw_a = 1'b1;
    wait_done(u, 300);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy_a"}, busy_a, 0);     chk({tag, "_done_a"}, done_a, 0);
    chk({tag, "_cs_a"}, rom_cs_a, 0);     chk({tag, "_raddr_a"}, rom_addr_a, 0);
    chk({tag, "_we_a"}, buf_we_a, 0);     chk({tag, "_baddr_a"}, buf_addr_a, 0);
    chk({tag, "_bdata_a"}, buf_data_a, 0);
    chk({tag, "_busy_b"}, busy_b, 0);     chk({tag, "_done_b"}, done_b, 0);
    chk({tag, "_cs_b"}, rom_cs_b, 0);     chk({tag, "_raddr_b"}, rom_addr_b, 0);
    chk({tag, "_we_b"}, buf_we_b, 0);     chk({tag, "_baddr_b"}, buf_addr_b, 0);
    chk({tag, "_bdata_b"}, buf_data_b, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = w | 32'hFFFF0000;
      else if ($urandom_range(0, 2) == 0) w = w | 32'h0000FFFF;
      mem_b[i] = w;
      if (i < 8192) mem_a[i] = w ^ 32'h5A5A0000;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed rows: wrap, hflip, transparency, 16-wide flipped
    mem_a[13'h0AAB] = 32'h0000000F;
    issue(0, 'h155, 'h1FE, 3, 1'b0, 1'b0, 5);
    issue(0, 'h155, 'h1FE, 3, 1'b1, 1'b0, 'hA);
    mem_a[13'h0101] = 32'hFFFF0000;
    issue(0, 'h020, 'h010, 1, 1'b0, 1'b0, 3);
    issue(1, 0, 'h040, 2, 1'b1, 1'b1, 7);

    for (int n = 0; n < 60; n++) begin
      int u;
      u = $urandom_range(0, 1);
      issue(u, $urandom_range(0, 1023), $urandom_range(0, 511),
            (u != 0) ? $urandom_range(0, 15) : $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end

    // Abort while the ROM never answers; a same-cycle draw must be dropped
    hold_low = 1'b1;
    push_ev(0, 2, ('h0C3 << 3) + 5, 0, -1);
    code = CW'('h0C3); ysub = 4'd5; vflip = 1'b0; hflip = 1'b0; xpos = '0; pal = 4'd2;
    draw_a = 1'b1;
    @(negedge clk);
    draw_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", busy_a, 1);
    chk("abort_cs_before", rom_cs_a, 1);
    abort = 1'b1; draw_a = 1'b1; code = CW'('h011);
    @(negedge clk);
    abort = 1'b0; draw_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_cs", rom_cs_a, 0);
    chk("abort_we", buf_we_a, 0);
    chk("abort_done", done_a, 0);
    repeat (4) @(negedge clk);
    chk("abort_drop_busy", busy_a, 0);
    chk("abort_drop_cs", rom_cs_a, 0);
    hold_low = 1'b0;
    #1;
    chk("abort_drained", evq.size(), 0);
    evq.delete();

    // Asynchronous reset in the middle of drawing
    mem_a[0] = 32'h0;
    push_req(0, 0, 'h100, 0, 1'b0, 1'b0, 1);
    code = '0; xpos = XW'('h100); ysub = '0; hflip = 1'b0; vflip = 1'b0; pal = 4'd1;
    draw_a = 1'b1;
    @(negedge clk);
    draw_a = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (buf_we_a) got = 1'b1;
    end
    chk("rst_reached_draw", int'(got), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    evq.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(0, 'h2F0, 'h0F8, 6, 1'b1, 1'b1, 9);
    issue(1, 'h3FF, 'h1F9, 15, 1'b0, 1'b1, 4);

    chk("final_queue", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
